// File: rtl/fb_scanout_if.sv
// Framebuffer RAM read port between the scanout engine and the RAM.
// Read data follows the address by one clock.
interface fb_scanout_if #(
    parameter int DATA = 18,
    parameter int ADDR = 14
);
    logic [ADDR-1:0] ram_addr;
    logic [DATA-1:0] ram_dout;

    modport master (output ram_addr, input ram_dout);
    modport slave (input ram_addr, output ram_dout);
endinterface

// File: rtl/fb_scanout.sv
// VGA 640x480@60 scanout of a small framebuffer, upscaled by SCALE.
// Pixel rate is half the clock; outputs trail the counters by one pixel.
module fb_scanout #(
    parameter int DATA         = 18,
    parameter int ADDR         = 14,
    parameter int FB_W         = 128,
    parameter int FB_H         = 96,
    parameter int SCALE        = 5,
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 752,
    parameter int H_TOTAL      = 800,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 492,
    parameter int V_TOTAL      = 525
) (
    input  logic                clk,
    input  logic                reset,
    fb_scanout_if.master        ram,
    output logic [5:0]          red,
    output logic [5:0]          green,
    output logic [5:0]          blue,
    output logic                hsync,
    output logic                vsync,
    output logic                vblank,
    output logic                frame_start
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int XW = $clog2(FB_W);
    localparam int YW = ADDR - XW;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_S0   = HW'(H_SYNC_START);
    localparam logic [HW-1:0] H_S1   = HW'(H_SYNC_END);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_S0   = VW'(V_SYNC_START);
    localparam logic [VW-1:0] V_S1   = VW'(V_SYNC_END);
    localparam logic [SW-1:0] S_LAST = SW'(SCALE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FB_H - 1);

    logic            pix_en_q, pix_en_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic [SW-1:0]   hsub_q, hsub_d;
    logic [SW-1:0]   vsub_q, vsub_d;
    logic [XW-1:0]   fbx_q, fbx_d;
    logic [YW-1:0]   fby_q, fby_d;
    logic [5:0]      red_q, red_d;
    logic [5:0]      green_q, green_d;
    logic [5:0]      blue_q, blue_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            vblank_q, vblank_d;
    logic            frame_start_q, frame_start_d;

    logic            h_wrap, v_wrap, h_act, v_act;
    logic [DATA-1:0] rd_word;

    assign rd_word      = ram.ram_dout;
    assign ram.ram_addr = {fby_q, fbx_q};

    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = (v_q == V_LAST);
    assign h_act  = (h_q < H_ACT);
    assign v_act  = (v_q < V_ACT);

    always_comb begin
        pix_en_d      = ~pix_en_q;
        h_d           = h_q;
        v_d           = v_q;
        hsub_d        = hsub_q;
        vsub_d        = vsub_q;
        fbx_d         = fbx_q;
        fby_d         = fby_q;
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        vblank_d      = vblank_q;
        frame_start_d = pix_en_q & h_wrap & v_wrap;

        if (pix_en_q) begin
            h_d = h_wrap ? '0 : h_q + 1'b1;
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + 1'b1;
            end

            // fbx wraps naturally at FB_W, leaving it 0 through h blanking
            if (h_wrap) begin
                hsub_d = '0;
                fbx_d  = '0;
            end else if (h_act) begin
                if (hsub_q == S_LAST) begin
                    hsub_d = '0;
                    fbx_d  = fbx_q + 1'b1;
                end else begin
                    hsub_d = hsub_q + 1'b1;
                end
            end

            if (h_wrap && v_wrap) begin
                vsub_d = '0;
                fby_d  = '0;
            end else if (h_wrap && v_act) begin
                if (vsub_q == S_LAST) begin
                    vsub_d = '0;
                    fby_d  = (fby_q == Y_LAST) ? '0 : fby_q + 1'b1;
                end else begin
                    vsub_d = vsub_q + 1'b1;
                end
            end

            // Data now on ram_dout belongs to the (h,v) being retired
            if (h_act && v_act) begin
                red_d   = rd_word[DATA-1 -: 6];
                green_d = rd_word[DATA-7 -: 6];
                blue_d  = rd_word[DATA-13 -: 6];
            end else begin
                red_d   = '0;
                green_d = '0;
                blue_d  = '0;
            end
            hsync_d  = ~((h_q >= H_S0) && (h_q < H_S1));
            vsync_d  = ~((v_q >= V_S0) && (v_q < V_S1));
            vblank_d = ~v_act;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_en_q      <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            hsub_q        <= '0;
            vsub_q        <= '0;
            fbx_q         <= '0;
            fby_q         <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            vblank_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pix_en_q      <= pix_en_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsub_q        <= hsub_d;
            vsub_q        <= vsub_d;
            fbx_q         <= fbx_d;
            fby_q         <= fby_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            vblank_q      <= vblank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vblank      = vblank_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: full-size instance for line timing, small-timing
// instance for frame-level behaviour, both against a position-based model.
module tb_fb_scanout;
    typedef struct {
        int ht; int ha; int hs0; int hs1;
        int vt; int va; int vs0; int vs1;
        int s; int fbw; int fbh;
    } tm_t;

    typedef struct {
        int addr; int rd_addr;
        bit act; bit hs; bit vs; bit vb; bit fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    logic rst_s = 1'b1;
    logic ones = 1'b0;
    bit   chk_en = 1'b0;
    int   mb = 0;
    int   ms = 0;
    int   n_total = 0;
    int   n_bad = 0;
    logic [17:0] smem [64];

    tm_t tm_b = '{800, 640, 656, 752, 525, 480, 490, 492, 5, 128, 96};
    tm_t tm_s = '{24, 16, 18, 21, 16, 12, 13, 15, 2, 8, 6};

    logic [5:0] b_r, b_g, b_bl, s_r, s_g, s_bl;
    logic b_hs, b_vs, b_vb, b_fs, s_hs, s_vs, s_vb, s_fs;

    fb_scanout_if #(.DATA(18), .ADDR(14)) big_if ();
    fb_scanout_if #(.DATA(18), .ADDR(6))  sml_if ();

    fb_scanout u_big (
        .clk(clk), .reset(rst_b), .ram(big_if),
        .red(b_r), .green(b_g), .blue(b_bl),
        .hsync(b_hs), .vsync(b_vs), .vblank(b_vb), .frame_start(b_fs)
    );

    fb_scanout #(
        .DATA(18), .ADDR(6), .FB_W(8), .FB_H(6), .SCALE(2),
        .H_ACTIVE(16), .H_SYNC_START(18), .H_SYNC_END(21), .H_TOTAL(24),
        .V_ACTIVE(12), .V_SYNC_START(13), .V_SYNC_END(15), .V_TOTAL(16)
    ) u_sml (
        .clk(clk), .reset(rst_s), .ram(sml_if),
        .red(s_r), .green(s_g), .blue(s_bl),
        .hsync(s_hs), .vsync(s_vs), .vblank(s_vb), .frame_start(s_fs)
    );

    initial forever #5 clk = ~clk;

    // RAM models: big one holds word[a] = a
    always @(posedge clk) begin
        big_if.ram_dout <= 18'(big_if.ram_addr);
        sml_if.ram_dout <= ones ? 18'h3ffff : smem[sml_if.ram_addr];
    end

    // clocks since the last edge that saw reset
    always @(posedge clk) begin
        mb <= rst_b ? 0 : mb + 1;
        ms <= rst_s ? 0 : ms + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int fb_addr(int h, int v, tm_t t);
        int x, y;
        x = (((h < t.ha) ? h : t.ha) / t.s) % t.fbw;
        y = (((v < t.va) ? v : t.va) / t.s) % t.fbh;
        return y * t.fbw + x;
    endfunction

    // m clocks after reset: m/2 pixels scanned, outputs show the one before
    function automatic exp_t exp_at(int m, tm_t t);
        exp_t e;
        int p, fr, q, h, v;
        fr = t.ht * t.vt;
        p = m / 2;
        q = p % fr;
        e.addr = fb_addr(q % t.ht, q / t.ht, t);
        e.fs = (m > 0) && (m % 2 == 0) && (q == 0);
        if (p == 0) begin
            e.rd_addr = 0; e.act = 0; e.hs = 1; e.vs = 1; e.vb = 0;
        end else begin
            q = (p - 1) % fr;
            h = q % t.ht;
            v = q / t.ht;
            e.rd_addr = fb_addr(h, v, t);
            e.act = (h < t.ha) && (v < t.va);
            e.hs = !((h >= t.hs0) && (h < t.hs1));
            e.vs = !((v >= t.vs0) && (v < t.vs1));
            e.vb = (v >= t.va);
        end
        return e;
    endfunction

    always @(negedge clk) begin : per_clk
        exp_t eb, es;
        logic [17:0] wb, ws;
        if (chk_en) begin
            eb = exp_at(mb, tm_b);
            wb = eb.act ? 18'(eb.rd_addr) : 18'd0;
            chk("big_out", {b_fs, b_vb, b_vs, b_hs, b_r, b_g, b_bl},
                {eb.fs, eb.vb, eb.vs, eb.hs, wb});
            chk("big_addr", 32'(big_if.ram_addr), eb.addr);
            es = exp_at(ms, tm_s);
            ws = es.act ? (ones ? 18'h3ffff : smem[es.rd_addr]) : 18'd0;
            chk("sml_out", {s_fs, s_vb, s_vs, s_hs, s_r, s_g, s_bl},
                {es.fs, es.vb, es.vs, es.hs, ws});
            chk("sml_addr", 32'(sml_if.ram_addr), es.addr);
        end
    end

    task automatic run_big();
        int f0, f1, r0, first, guard;
        logic phs;
        f0 = -1; f1 = -1; r0 = -1; first = -1; guard = 0;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        phs = 1'b1;
        while (mb != 32600 && guard < 40000) begin
            @(negedge clk);
            guard++;
            if (phs && !b_hs) begin
                if (f0 < 0) f0 = mb;
                else if (f1 < 0) f1 = mb;
            end
            if (!phs && b_hs && f0 >= 0 && r0 < 0) r0 = mb;
            phs = b_hs;
            if (mb == 2 * (12 * 800 + 7 + 1))
                chk("px_7_12", {b_r, b_g, b_bl}, 257);
        end
        chk("big_run", mb, 32600);
        chk("hs_period", f1 - f0, 1600);
        chk("hs_low", r0 - f0, 192);
        // counters now sit at h=300, v=20
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        chk("rst_hs", b_hs, 1);
        chk("rst_vs", b_vs, 1);
        chk("rst_rgb", {b_r, b_g, b_bl}, 0);
        chk("rst_addr", big_if.ram_addr, 0);
        for (int i = 0; i < 3000 && first < 0; i++) begin
            @(negedge clk);
            if (!b_hs) first = mb;
        end
        chk("hs_first", first, 2 * (656 + 1));
    endtask

    task automatic run_sml();
        int fs_m[$];
        int vf[$];
        int cnt[64];
        int vr, amax, bad, nz, a, n_fs;
        logic pvs, pfs;
        exp_t e;
        foreach (smem[i]) smem[i] = 18'($urandom);
        foreach (cnt[i]) cnt[i] = 0;
        vr = -1; amax = 0; bad = 0; nz = 0;
        repeat (3) @(negedge clk);
        rst_s = 1'b0;
        pvs = 1'b1; pfs = 1'b0;
        repeat (2310) begin
            @(negedge clk);
            if (s_fs && !pfs) fs_m.push_back(ms);
            if (pvs && !s_vs) vf.push_back(ms);
            if (!pvs && s_vs && vf.size() == 1 && vr < 0) vr = ms;
            pfs = s_fs;
            pvs = s_vs;
            if (ms >= 2 && ms < 770 && ms % 2 == 0) begin
                a = ((ms / 2) % 384);
                if ((a % 24) < 16 && (a / 24) < 12) begin
                    cnt[sml_if.ram_addr]++;
                    if (int'(sml_if.ram_addr) > amax) amax = sml_if.ram_addr;
                end
            end
        end
        n_fs = fs_m.size();
        chk("fs_count", n_fs, 3);
        while (fs_m.size() < 3) fs_m.push_back(-10000);
        while (vf.size() < 2) vf.push_back(-10000);
        chk("fs_first", fs_m[0], 768);
        chk("fs_gap1", fs_m[1] - fs_m[0], 768);
        chk("fs_gap2", fs_m[2] - fs_m[1], 768);
        chk("vs_period", vf[1] - vf[0], 768);
        chk("vs_low", vr - vf[0], 96);
        for (int i = 0; i < 64; i++)
            if (cnt[i] != ((i < 48) ? 4 : 0)) bad++;
        chk("addr_cnt_bad", bad, 0);
        chk("addr_max", amax, 47);

        repeat ($urandom_range(100, 700)) @(negedge clk);
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        chk("s_rst_addr", sml_if.ram_addr, 0);
        chk("s_rst_rgb", {s_r, s_g, s_bl}, 0);
        repeat (800) @(negedge clk);

        rst_s = 1'b1;
        @(negedge clk);
        ones = 1'b1;
        rst_s = 1'b0;
        repeat (800) begin
            @(negedge clk);
            e = exp_at(ms, tm_s);
            if (!e.act && ({s_r, s_g, s_bl} != 18'd0)) nz++;
        end
        chk("ones_blank_rgb", nz, 0);
    endtask

    initial begin
        fork
            run_big();
            run_sml();
            begin
                repeat (2) @(negedge clk);
                chk_en = 1'b1;
            end
        join
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
